// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller and its sensor front-end:
// light encodings and direction indices.
package traffic_pkg;

    typedef logic [1:0] light_t;

    localparam light_t LIGHT_RED    = 2'b00;
    localparam light_t LIGHT_YELLOW = 2'b01;
    localparam light_t LIGHT_GREEN  = 2'b10;

    localparam int DIR_NS   = 0;
    localparam int DIR_SN   = 1;
    localparam int DIR_EW   = 2;
    localparam int DIR_WE   = 3;
    localparam int NUM_DIRS = 4;

endpackage

// File: rtl/tqs_lane.sv
// One direction of the queue sensor: two-flop synchronizers on the arrival and
// stop-line loops, debounce filter, rising-edge event detect, saturating queue
// counter and the S5 congestion flag with hysteresis.
// With TQS_VIOLATION_EN defined the lane also flags departures seen on red.
module tqs_lane
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 5,
    parameter int S5_ON           = 8,
    parameter int S5_OFF          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arr,
    input  logic             dep,
`ifdef TQS_VIOLATION_EN
    input  logic [1:0]       light,
    output logic             viol,
`endif
    output logic             s1,
    output logic             s5,
    output logic [CNT_W-1:0] q
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the next mismatch commits.
    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_Q   = '1;
    localparam logic [CNT_W-1:0] ON_THR  = CNT_W'(S5_ON);
    localparam logic [CNT_W-1:0] OFF_THR = CNT_W'(S5_OFF);

    // Bit 0 carries the arrival loop, bit 1 the departure loop.
    logic [1:0]       ff1;
    logic [1:0]       ff2;
    logic [1:0]       filt;
    logic [1:0]       filt_q;
    logic [1:0]       ev;
    logic [DB_W-1:0]  stable_cnt [2];
    logic             arr_ev;
    logic             dep_ev;
    logic [CNT_W-1:0] q_next;

    // Synchronize both loops and debounce: filt follows ff2 only after
    // DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1    <= '0;
            ff2    <= '0;
            filt   <= '0;
            filt_q <= '0;
            for (int i = 0; i < 2; i++) stable_cnt[i] <= '0;
        end else begin
            ff1    <= {dep, arr};
            ff2    <= ff1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (ff2[i] == filt[i]) begin
                    stable_cnt[i] <= '0;
                end else if (stable_cnt[i] == DB_TC) begin
                    filt[i]       <= ff2[i];
                    stable_cnt[i] <= '0;
                end else begin
                    stable_cnt[i] <= stable_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign ev     = filt & ~filt_q;
    assign arr_ev = ev[0];
    assign dep_ev = ev[1];

    // Next queue count; simultaneous arrival and departure cancel out.
    always_comb begin
        q_next = q;
        if (arr_ev && !dep_ev && (q != MAX_Q)) begin
            q_next = q + 1'b1;
        end else if (dep_ev && !arr_ev && (q != '0)) begin
            q_next = q - 1'b1;
        end
    end

    // Queue count and congestion flag move together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            s5 <= 1'b0;
        end else begin
            q <= q_next;
            if (q_next >= ON_THR) begin
                s5 <= 1'b1;
            end else if (q_next <= OFF_THR) begin
                s5 <= 1'b0;
            end
        end
    end

    assign s1 = (q != '0);

`ifdef TQS_VIOLATION_EN
    // One-cycle pulse when a vehicle crosses the stop line on red.
    always_ff @(posedge clk) begin
        if (rst) begin
            viol <= 1'b0;
        end else begin
            viol <= dep_ev && (light == LIGHT_RED);
        end
    end
`endif

endmodule

// File: rtl/traffic_queue_sensor.sv
// Four-direction loop-detector front-end feeding the traffic light controller's
// S1 (cars present) and S5 (congestion) inputs. Each direction is an identical
// tqs_lane; this level only maps the named pins onto the lanes.
// Optional feature macro: TQS_VIOLATION_EN adds the viol_* red-light outputs.
module traffic_queue_sensor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 5,
    parameter int S5_ON           = 8,
    parameter int S5_OFF          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arr_NS,
    input  logic             arr_SN,
    input  logic             arr_EW,
    input  logic             arr_WE,
    input  logic             dep_NS,
    input  logic             dep_SN,
    input  logic             dep_EW,
    input  logic             dep_WE,
    input  logic [1:0]       NS_light,
    input  logic [1:0]       SN_light,
    input  logic [1:0]       EW_light,
    input  logic [1:0]       WE_light,
`ifdef TQS_VIOLATION_EN
    output logic             viol_NS,
    output logic             viol_SN,
    output logic             viol_EW,
    output logic             viol_WE,
`endif
    output logic             S1_NS,
    output logic             S1_SN,
    output logic             S1_EW,
    output logic             S1_WE,
    output logic             S5_NS,
    output logic             S5_SN,
    output logic             S5_EW,
    output logic             S5_WE,
    output logic [CNT_W-1:0] q_NS,
    output logic [CNT_W-1:0] q_SN,
    output logic [CNT_W-1:0] q_EW,
    output logic [CNT_W-1:0] q_WE
);

    localparam int MAX_Q = 2**CNT_W - 1;

    generate
        if (!((S5_OFF < S5_ON) && (S5_ON <= MAX_Q))) begin : g_bad_thresholds
            $error("traffic_queue_sensor: need S5_OFF < S5_ON <= 2**CNT_W-1");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("traffic_queue_sensor: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [NUM_DIRS-1:0] arr_v;
    logic [NUM_DIRS-1:0] dep_v;
    logic [NUM_DIRS-1:0] s1_v;
    logic [NUM_DIRS-1:0] s5_v;
    logic [CNT_W-1:0]    q_v [NUM_DIRS];

    assign arr_v[DIR_NS] = arr_NS;
    assign arr_v[DIR_SN] = arr_SN;
    assign arr_v[DIR_EW] = arr_EW;
    assign arr_v[DIR_WE] = arr_WE;
    assign dep_v[DIR_NS] = dep_NS;
    assign dep_v[DIR_SN] = dep_SN;
    assign dep_v[DIR_EW] = dep_EW;
    assign dep_v[DIR_WE] = dep_WE;

`ifdef TQS_VIOLATION_EN
    logic [1:0]          light_v [NUM_DIRS];
    logic [NUM_DIRS-1:0] viol_v;

    assign light_v[DIR_NS] = NS_light;
    assign light_v[DIR_SN] = SN_light;
    assign light_v[DIR_EW] = EW_light;
    assign light_v[DIR_WE] = WE_light;

    assign viol_NS = viol_v[DIR_NS];
    assign viol_SN = viol_v[DIR_SN];
    assign viol_EW = viol_v[DIR_EW];
    assign viol_WE = viol_v[DIR_WE];
`else
    // Light states only matter for violation detection.
    logic unused_lights;
    assign unused_lights = ^{NS_light, SN_light, EW_light, WE_light};
`endif

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_lane
        tqs_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .S5_ON          (S5_ON),
            .S5_OFF         (S5_OFF)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .arr  (arr_v[i]),
            .dep  (dep_v[i]),
`ifdef TQS_VIOLATION_EN
            .light(light_v[i]),
            .viol (viol_v[i]),
`endif
            .s1   (s1_v[i]),
            .s5   (s5_v[i]),
            .q    (q_v[i])
        );
    end

    assign S1_NS = s1_v[DIR_NS];
    assign S1_SN = s1_v[DIR_SN];
    assign S1_EW = s1_v[DIR_EW];
    assign S1_WE = s1_v[DIR_WE];
    assign S5_NS = s5_v[DIR_NS];
    assign S5_SN = s5_v[DIR_SN];
    assign S5_EW = s5_v[DIR_EW];
    assign S5_WE = s5_v[DIR_WE];
    assign q_NS  = q_v[DIR_NS];
    assign q_SN  = q_v[DIR_SN];
    assign q_EW  = q_v[DIR_EW];
    assign q_WE  = q_v[DIR_WE];

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Bench for traffic_queue_sensor (default parameters). Stimulus is a per-cycle
// plan of loop levels: directed vehicle scenarios followed by random clean
// pulses/glitches. The reference model works at vehicle level: a loop pulse of
// at least DEBOUNCE_CYCLES samples is one event, landing DEBOUNCE_CYCLES+2
// edges after its first sample; queue, S5 and violations follow from events.
module tb_traffic_queue_sensor;
    import traffic_pkg::*;

    localparam int D         = 3;
    localparam int MAXQ      = 31;
    localparam int ON_T      = 8;
    localparam int OFF_T     = 5;
    localparam int NCYC      = 1600;
    localparam int RND_START = 300;
    localparam int RND_END   = 1550;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] arr_i;
    logic [3:0] dep_i;
    logic [1:0] light_i [4];
    wire  [3:0] s1_o;
    wire  [3:0] s5_o;
    wire  [4:0] q_o [4];
`ifdef TQS_VIOLATION_EN
    wire  [3:0] viol_o;
`endif

    traffic_queue_sensor dut (
        .clk     (clk),
        .rst     (rst),
        .arr_NS  (arr_i[0]),
        .arr_SN  (arr_i[1]),
        .arr_EW  (arr_i[2]),
        .arr_WE  (arr_i[3]),
        .dep_NS  (dep_i[0]),
        .dep_SN  (dep_i[1]),
        .dep_EW  (dep_i[2]),
        .dep_WE  (dep_i[3]),
        .NS_light(light_i[0]),
        .SN_light(light_i[1]),
        .EW_light(light_i[2]),
        .WE_light(light_i[3]),
`ifdef TQS_VIOLATION_EN
        .viol_NS (viol_o[0]),
        .viol_SN (viol_o[1]),
        .viol_EW (viol_o[2]),
        .viol_WE (viol_o[3]),
`endif
        .S1_NS   (s1_o[0]),
        .S1_SN   (s1_o[1]),
        .S1_EW   (s1_o[2]),
        .S1_WE   (s1_o[3]),
        .S5_NS   (s5_o[0]),
        .S5_SN   (s5_o[1]),
        .S5_EW   (s5_o[2]),
        .S5_WE   (s5_o[3]),
        .q_NS    (q_o[0]),
        .q_SN    (q_o[1]),
        .q_EW    (q_o[2]),
        .q_WE    (q_o[3])
    );

    // Plan: raw_pl[dir][0=arrival,1=departure][sampling edge]
    bit         raw_pl   [4][2][NCYC];
    logic [1:0] light_pl [4][NCYC];
    bit         ev_pl    [4][2][NCYC];
    int         exp_q    [4][NCYC];
    bit         exp_s5   [4][NCYC];
    bit         exp_viol [4][NCYC];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic add_pulse(input int d, input int t, input int start, input int len);
        for (int i = start; i < start + len; i++)
            if (i < NCYC) raw_pl[d][t][i] = 1'b1;
    endtask

    task automatic build_plan();
        int pos;
        int len;
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < NCYC; c++) light_pl[d][c] = LIGHT_RED;
        // NS: one vehicle, then a 2-cycle glitch
        add_pulse(DIR_NS, 0, 0, 4);
        add_pulse(DIR_NS, 0, 10, 2);
        // EW: 8 arrivals, 3 departures, 2 arrivals (hysteresis walk)
        for (int i = 0; i < 8; i++) add_pulse(DIR_EW, 0, 20 + 8 * i, 4);
        for (int i = 0; i < 3; i++) add_pulse(DIR_EW, 1, 90 + 8 * i, 4);
        for (int i = 0; i < 2; i++) add_pulse(DIR_EW, 0, 120 + 8 * i, 4);
        // WE: 32 arrivals into a 31-deep counter
        for (int i = 0; i < 32; i++) add_pulse(DIR_WE, 0, 20 + 8 * i, 4);
        // SN: departure on empty, 3 arrivals, simultaneous pair, red/green departures
        add_pulse(DIR_SN, 1, 20, 4);
        for (int i = 0; i < 3; i++) add_pulse(DIR_SN, 0, 40 + 8 * i, 4);
        add_pulse(DIR_SN, 0, 70, 4);
        add_pulse(DIR_SN, 1, 70, 4);
        add_pulse(DIR_SN, 1, 90, 4);
        add_pulse(DIR_SN, 1, 100, 4);
        for (int c = 100; c <= 110; c++) light_pl[DIR_SN][c] = LIGHT_GREEN;
        // Random segment: pulses 1..6 long (short ones are glitches), gaps >= D
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < 2; t++) begin
                pos = RND_START + int'($urandom_range(3, 10));
                while (pos < RND_END) begin
                    len = int'($urandom_range(1, 6));
                    add_pulse(d, t, pos, len);
                    pos += len + int'($urandom_range(D, 10));
                end
            end
            for (int c = RND_START; c < NCYC; c++)
                light_pl[d][c] = 2'(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic build_model();
        int c;
        int len;
        int q;
        bit s5;
        bit a;
        bit p;
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < 2; t++) begin
                c = 0;
                while (c < NCYC) begin
                    if (raw_pl[d][t][c]) begin
                        len = 0;
                        while ((c + len < NCYC) && raw_pl[d][t][c + len]) len++;
                        if ((len >= D) && (c + D + 2 < NCYC)) ev_pl[d][t][c + D + 2] = 1'b1;
                        c += len;
                    end else begin
                        c++;
                    end
                end
            end
            q  = 0;
            s5 = 1'b0;
            for (int k = 0; k < NCYC; k++) begin
                a = ev_pl[d][0][k];
                p = ev_pl[d][1][k];
                if (a && !p) q = (q == MAXQ) ? MAXQ : q + 1;
                else if (p && !a) q = (q == 0) ? 0 : q - 1;
                if (q >= ON_T) s5 = 1'b1;
                else if (q <= OFF_T) s5 = 1'b0;
                exp_q[d][k]    = q;
                exp_s5[d][k]   = s5;
                exp_viol[d][k] = p && (light_pl[d][k] == LIGHT_RED);
            end
        end
    endtask

    task automatic drive(input int c);
        for (int d = 0; d < 4; d++) begin
            arr_i[d]   = raw_pl[d][0][c];
            dep_i[d]   = raw_pl[d][1][c];
            light_i[d] = light_pl[d][c];
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_q%0d", tag, d), int'(q_o[d]), 0);
            chk($sformatf("%s_s1_%0d", tag, d), int'(s1_o[d]), 0);
            chk($sformatf("%s_s5_%0d", tag, d), int'(s5_o[d]), 0);
`ifdef TQS_VIOLATION_EN
            chk($sformatf("%s_viol%0d", tag, d), int'(viol_o[d]), 0);
`endif
        end
    endtask

    task automatic check_model(input int c);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("q%0d@%0d", d, c), int'(q_o[d]), exp_q[d][c]);
            chk($sformatf("s1_%0d@%0d", d, c), int'(s1_o[d]), int'(exp_q[d][c] != 0));
            chk($sformatf("s5_%0d@%0d", d, c), int'(s5_o[d]), int'(exp_s5[d][c]));
`ifdef TQS_VIOLATION_EN
            chk($sformatf("viol%0d@%0d", d, c), int'(viol_o[d]), int'(exp_viol[d][c]));
`endif
        end
    endtask

    // Hand-derived checkpoints for the directed part of the plan.
    task automatic check_directed(input int c);
        case (c)
            4:   chk("lat_pre_qNS", int'(q_o[DIR_NS]), 0);
            5: begin
                chk("lat_qNS", int'(q_o[DIR_NS]), 1);
                chk("lat_S1NS", int'(s1_o[DIR_NS]), 1);
            end
            20:  chk("glitch_qNS", int'(q_o[DIR_NS]), 1);
            25:  chk("dep_empty_qSN", int'(q_o[DIR_SN]), 0);
            75:  chk("simul_qSN", int'(q_o[DIR_SN]), 3);
            80:  chk("pre_set_S5EW", int'(s5_o[DIR_EW]), 0);
            81: begin
                chk("set_qEW", int'(q_o[DIR_EW]), 8);
                chk("set_S5EW", int'(s5_o[DIR_EW]), 1);
            end
            95: begin
                chk("red_dep_qSN", int'(q_o[DIR_SN]), 2);
`ifdef TQS_VIOLATION_EN
                chk("red_viol_SN", int'(viol_o[DIR_SN]), 1);
`endif
            end
`ifdef TQS_VIOLATION_EN
            96:  chk("red_viol_SN_end", int'(viol_o[DIR_SN]), 0);
`endif
            103: begin
                chk("hold_qEW", int'(q_o[DIR_EW]), 6);
                chk("hold_S5EW", int'(s5_o[DIR_EW]), 1);
            end
            105: begin
                chk("green_dep_qSN", int'(q_o[DIR_SN]), 1);
`ifdef TQS_VIOLATION_EN
                chk("green_viol_SN", int'(viol_o[DIR_SN]), 0);
`endif
            end
            111: begin
                chk("clear_qEW", int'(q_o[DIR_EW]), 5);
                chk("clear_S5EW", int'(s5_o[DIR_EW]), 0);
            end
            133: begin
                chk("reup_qEW", int'(q_o[DIR_EW]), 7);
                chk("reup_S5EW", int'(s5_o[DIR_EW]), 0);
            end
            280: chk("sat_qWE", int'(q_o[DIR_WE]), 31);
            default: ;
        endcase
    endtask

    initial begin
        rst   = 1'b1;
        arr_i = '0;
        dep_i = '0;
        for (int d = 0; d < 4; d++) light_i[d] = LIGHT_RED;
        build_plan();
        build_model();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst");

        rst = 1'b0;
        drive(0);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_model(c);
            check_directed(c);
            if (c + 1 < NCYC) drive(c + 1);
        end

        // Reset in the middle of operation with a loop held high.
        rst   = 1'b1;
        arr_i = '0;
        dep_i = '0;
        for (int d = 0; d < 4; d++) light_i[d] = LIGHT_RED;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst2");
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            arr_i[DIR_NS] = (c < 88) ? ((c % 8) < 4) : 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_qNS", int'(q_o[DIR_NS]), 12);
        chk("mid_S5NS", int'(s5_o[DIR_NS]), 1);
        chk("mid_S1NS", int'(s1_o[DIR_NS]), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("rst3");
        rst = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 4) chk("rel_pre_qNS", int'(q_o[DIR_NS]), 0);
            if (e == 5) begin
                chk("rel_qNS", int'(q_o[DIR_NS]), 1);
                chk("rel_S1NS", int'(s1_o[DIR_NS]), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
